// File: rtl/irrigation_pkg.sv
// Shared definitions for the irrigation countdown timer: FSM encoding,
// BCD digit type, digit limits and the preset saturation helper.
package irrigation_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t UNITS_MAX    = 4'd9;

    // Clamp a preset digit to the largest value its position may hold.
    function automatic bcd_t sat_digit(input bcd_t value, input bcd_t max_value);
        bcd_t result;
        if (value > max_value) begin
            result = max_value;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/irrigation_countdown_digit.sv
// One BCD down-counting digit. Wraps 0 -> MAX when decremented and flags a
// borrow to the next-higher digit in that same cycle.
module bcd_down_digit
    import irrigation_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic clk,
    input  logic clear_n,
    input  logic load,
    input  bcd_t load_val,
    input  logic dec_en,
    input  logic zero,
    output bcd_t digit,
    output logic borrow_out
);

    localparam bcd_t WRAP_VAL = 4'(MAX);

    bcd_t digit_q;
    bcd_t digit_d;

    // Next digit value: zero beats load beats decrement.
    always_comb begin
        digit_d = digit_q;
        if (zero) begin
            digit_d = 4'd0;
        end else if (load) begin
            digit_d = load_val;
        end else if (dec_en) begin
            if (digit_q == 4'd0) begin
                digit_d = WRAP_VAL;
            end else begin
                digit_d = digit_q - 4'd1;
            end
        end else begin
            digit_d = digit_q;
        end
    end

    // Digit register, cleared asynchronously.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign borrow_out = dec_en & (digit_q == 4'd0);

endmodule

// File: rtl/irrigation_countdown.sv
// mm:ss countdown timer for one watering cycle. Holds the control FSM,
// preset saturation, zero/one detect and the four-digit borrow chain.
module irrigation_countdown
    import irrigation_pkg::*;
#(
    parameter int MIN_TENS_MAX = 5
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic        tick,
    input  logic        load,
    input  logic [15:0] preset,
    input  logic        start,
    input  logic        stop,
    input  logic        abort,
    output logic [15:0] digits,
    output logic        valve,
    output logic        running,
    output logic        done,
    output logic        done_pulse
);

    localparam bcd_t MIN_TENS_LIM = 4'(MIN_TENS_MAX);

    state_e state_q;
    state_e state_d;
    logic   done_pulse_q;
    logic   done_pulse_d;

    logic   zero_s;
    logic   load_s;
    logic   run_tick_s;
    logic   count_zero_s;
    logic   count_one_s;
    bcd_t   preset_sat_s [4];
    bcd_t   digit_s      [4];
    logic   borrow_s     [4];
    logic   dec_en_s     [4];

    assign count_zero_s = (digits == 16'h0000);
    assign count_one_s  = (digits == 16'h0001);

    // Saturate each preset digit to the largest value legal for its position.
    always_comb begin
        preset_sat_s[0] = sat_digit(preset[3:0],   UNITS_MAX);
        preset_sat_s[1] = sat_digit(preset[7:4],   SEC_TENS_MAX);
        preset_sat_s[2] = sat_digit(preset[11:8],  UNITS_MAX);
        preset_sat_s[3] = sat_digit(preset[15:12], MIN_TENS_LIM);
    end

    // Command decode and next state: abort > load > stop > start > tick.
    always_comb begin
        state_d      = state_q;
        zero_s       = 1'b0;
        load_s       = 1'b0;
        run_tick_s   = 1'b0;
        done_pulse_d = 1'b0;
        if (abort) begin
            zero_s  = 1'b1;
            state_d = ST_IDLE;
        end else if (load && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
            load_s  = 1'b1;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop && !count_zero_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        run_tick_s = 1'b1;
                        if (count_one_s) begin
                            state_d      = ST_DONE;
                            done_pulse_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (start && !stop) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Borrow chain: each digit decrements only when all lower digits borrow.
    always_comb begin
        dec_en_s[0] = run_tick_s;
        dec_en_s[1] = borrow_s[0];
        dec_en_s[2] = borrow_s[1];
        dec_en_s[3] = borrow_s[2];
    end

    // FSM state and done pulse registers.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q      <= ST_IDLE;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    bcd_down_digit #(.MAX(9)) u_sec_units (
        .clk(clk), .clear_n(clear_n), .load(load_s), .load_val(preset_sat_s[0]),
        .dec_en(dec_en_s[0]), .zero(zero_s), .digit(digit_s[0]), .borrow_out(borrow_s[0])
    );

    bcd_down_digit #(.MAX(5)) u_sec_tens (
        .clk(clk), .clear_n(clear_n), .load(load_s), .load_val(preset_sat_s[1]),
        .dec_en(dec_en_s[1]), .zero(zero_s), .digit(digit_s[1]), .borrow_out(borrow_s[1])
    );

    bcd_down_digit #(.MAX(9)) u_min_units (
        .clk(clk), .clear_n(clear_n), .load(load_s), .load_val(preset_sat_s[2]),
        .dec_en(dec_en_s[2]), .zero(zero_s), .digit(digit_s[2]), .borrow_out(borrow_s[2])
    );

    // The minute-tens digit never wraps in practice: the count stops at 0000.
    bcd_down_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .clear_n(clear_n), .load(load_s), .load_val(preset_sat_s[3]),
        .dec_en(dec_en_s[3]), .zero(zero_s), .digit(digit_s[3]), .borrow_out(borrow_s[3])
    );

    assign digits     = {digit_s[3], digit_s[2], digit_s[1], digit_s[0]};
    assign valve      = (state_q == ST_RUN);
    assign running    = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign done       = (state_q == ST_DONE);
    assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_irrigation_countdown.sv
// Directed self-checking bench for irrigation_countdown.
module tb_irrigation_countdown;

    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic        tick = 1'b0;
    logic        load = 1'b0;
    logic [15:0] preset = 16'h0000;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        abort = 1'b0;

    logic [15:0] digits;
    logic        valve;
    logic        running;
    logic        done;
    logic        done_pulse;

    logic [15:0] digits9;
    logic        valve9;
    logic        running9;
    logic        done9;
    logic        done_pulse9;

    int errors = 0;
    int checks = 0;

    irrigation_countdown #(.MIN_TENS_MAX(5)) dut (
        .clk(clk), .clear_n(clear_n), .tick(tick), .load(load), .preset(preset),
        .start(start), .stop(stop), .abort(abort), .digits(digits), .valve(valve),
        .running(running), .done(done), .done_pulse(done_pulse)
    );

    irrigation_countdown #(.MIN_TENS_MAX(9)) dut9 (
        .clk(clk), .clear_n(clear_n), .tick(tick), .load(load), .preset(preset),
        .start(start), .stop(stop), .abort(abort), .digits(digits9), .valve(valve9),
        .running(running9), .done(done9), .done_pulse(done_pulse9)
    );

    always #5 clk = ~clk;

    // Independent seconds -> mm:ss BCD conversion.
    function automatic logic [15:0] to_bcd(input int secs);
        int mm;
        int ss;
        mm = secs / 60;
        ss = secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply the given command inputs for one clock, sample #1 after the edge.
    task automatic cyc(input logic t, input logic ld, input logic [15:0] p,
                       input logic st, input logic sp, input logic ab);
        tick = t; load = ld; preset = p; start = st; stop = sp; abort = ab;
        @(posedge clk);
        #1;
        tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; abort = 1'b0;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_digits", digits, 16'h0000);
        chk("rst_valve", {15'd0, valve}, 16'd0);
        chk("rst_running", {15'd0, running}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_pulse", {15'd0, done_pulse}, 16'd0);
        @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);

        // Tick in IDLE is ignored; start with zero count stays IDLE
        cyc(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("idle_zero_start", {15'd0, running}, 16'd0);
        chk("idle_tick", digits, 16'h0000);

        // 12-second run to DONE
        cyc(1'b0, 1'b1, 16'h0012, 1'b0, 1'b0, 1'b0);
        chk("load12", digits, 16'h0012);
        cyc(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("start_tick_ignored", digits, 16'h0012);
        chk("start_valve", {15'd0, valve}, 16'd1);
        for (int k = 1; k <= 11; k++) begin
            cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
            chk("run12_digits", digits, to_bcd(12 - k));
            chk("run12_nopulse", {15'd0, done_pulse}, 16'd0);
        end
        chk("run12_valve_before", {15'd0, valve}, 16'd1);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("end_digits", digits, 16'h0000);
        chk("end_pulse", {15'd0, done_pulse}, 16'd1);
        chk("end_done", {15'd0, done}, 16'd1);
        chk("end_valve", {15'd0, valve}, 16'd0);
        chk("end_running", {15'd0, running}, 16'd0);
        cyc(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("pulse_one_cycle", {15'd0, done_pulse}, 16'd0);
        chk("done_holds", {15'd0, done}, 16'd1);
        chk("done_no_wrap", digits, 16'h0000);

        // Minute borrow: 1000 -> 0959 -> 0958
        cyc(1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
        chk("load_clears_done", {15'd0, done}, 16'd0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("borrow_0959", digits, 16'h0959);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("borrow_0958", digits, 16'h0958);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("abort_digits", digits, 16'h0000);

        // sec_tens wraps to 5
        cyc(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("wrap_0059", digits, 16'h0059);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Pause and resume from 0030
        cyc(1'b0, 1'b1, 16'h0030, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        end
        chk("pre_pause", digits, 16'h0027);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        chk("pause_valve", {15'd0, valve}, 16'd0);
        chk("pause_running", {15'd0, running}, 16'd1);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        end
        chk("pause_hold", digits, 16'h0027);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("resume_valve", {15'd0, valve}, 16'd1);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("resume_0026", digits, 16'h0026);

        // start+stop together in RUN -> PAUSE
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        chk("startstop_valve", {15'd0, valve}, 16'd0);
        chk("startstop_running", {15'd0, running}, 16'd1);

        // abort+load in RUN -> 0000, IDLE
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("rerun_valve", {15'd0, valve}, 16'd1);
        cyc(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
        chk("abortload_digits", digits, 16'h0000);
        chk("abortload_running", {15'd0, running}, 16'd0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("zero_start_idle", {15'd0, running}, 16'd0);

        // Preset saturation
        cyc(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        chk("sat_mt5", digits, 16'h5959);
        chk("sat_mt9", digits9, 16'h9959);

        // Asynchronous reset mid-RUN
        cyc(1'b0, 1'b1, 16'h0030, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("pre_reset", digits, 16'h0029);
        #2;
        clear_n = 1'b0;
        #1;
        chk("async_valve", {15'd0, valve}, 16'd0);
        chk("async_digits", digits, 16'h0000);
        @(negedge clk);
        clear_n = 1'b1;
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("post_reset_tick", digits, 16'h0000);
        chk("post_reset_running", {15'd0, running}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
